// File: rtl/calc_window_stats_if.sv
// Sample/statistics bundle for calc_window_stats.
// Master drives samples and control; slave returns the window statistics.
interface calc_window_stats_if #(
    parameter int DW    = 3,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]      wdata;
    logic               wable;
    logic               clr;
    logic               slide;
    logic [DW+AW-1:0]   wsum;
    logic [2*DW+AW-1:0] w2sum;
    logic [AW:0]        wcount;
    logic               wfull;
    logic               wvalid;
    logic               mode;

    modport master (
        output wdata, wable, clr, slide,
        input  wsum, w2sum, wcount, wfull, wvalid, mode
    );

    modport slave (
        input  wdata, wable, clr, slide,
        output wsum, w2sum, wcount, wfull, wvalid, mode
    );
endinterface

// File: rtl/calc_window_stats.sv
// Sliding / cumulative window sum and sum-of-squares accumulator.
// The circular buffer is never cleared; eviction is gated by wfull and mode.
module calc_window_stats #(
    parameter int DW         = 3,
    parameter int DEPTH      = 256,
    parameter bit SLIDE_INIT = 1'b1
) (
    input logic                clk,
    input logic                reset,
    calc_window_stats_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DW + AW;
    localparam int QW = 2 * DW + AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT = (AW + 1)'(DEPTH - 1);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [SW-1:0]   sum_q;
    logic [QW-1:0]   sq_q;
    logic [AW:0]     cnt_q;
    logic            full_q;
    logic            valid_q;
    logic            mode_q;

    logic            accept;
    logic            evict;
    logic [DW-1:0]   old;
    logic [2*DW-1:0] d_sq;
    logic [2*DW-1:0] old_sq;
    logic [SW-1:0]   sum_sub;
    logic [QW-1:0]   sq_sub;

    assign accept = bus.wable && !bus.clr;
    assign evict  = full_q && mode_q;
    assign old    = mem[wptr];
    assign d_sq   = {{DW{1'b0}}, bus.wdata} * {{DW{1'b0}}, bus.wdata};
    assign old_sq = {{DW{1'b0}}, old} * {{DW{1'b0}}, old};

    // Oldest entry is only subtracted once the sliding window is full
    always_comb begin
        sum_sub = '0;
        sq_sub  = '0;
        if (evict) begin
            sum_sub = SW'(old);
            sq_sub  = QW'(old_sq);
        end
    end

    // Sample storage; contents survive reset and clear
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= bus.wdata;
        end
    end

    // Accumulators, occupancy, pointer, mode and valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            sq_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            wptr    <= '0;
            valid_q <= 1'b0;
            mode_q  <= SLIDE_INIT;
        end else if (bus.clr) begin
            sum_q   <= '0;
            sq_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            wptr    <= '0;
            valid_q <= 1'b0;
            mode_q  <= bus.slide;
        end else if (bus.wable) begin
            sum_q   <= sum_q + SW'(bus.wdata) - sum_sub;
            sq_q    <= sq_q + QW'(d_sq) - sq_sub;
            wptr    <= wptr + 1'b1;
            valid_q <= 1'b1;
            if (!full_q) begin
                cnt_q  <= cnt_q + 1'b1;
                full_q <= (cnt_q == LAST_CNT);
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.wsum   = sum_q;
    assign bus.w2sum  = sq_q;
    assign bus.wcount = cnt_q;
    assign bus.wfull  = full_q;
    assign bus.wvalid = valid_q;
    assign bus.mode   = mode_q;

    logic unused_ok;
    assign unused_ok = ^{FULL_CNT};
endmodule

// File: tb/tb_calc_window_stats.sv
// Scoreboard bench for calc_window_stats with DW=3, DEPTH=4.
// Stimulus pushes hand-computed results; a negedge monitor pops on wvalid.
module tb_calc_window_stats;
    localparam int DW    = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0] s;
        logic [7:0] q;
        logic [2:0] c;
        logic       f;
        logic       m;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic exp_mode;
    exp_t sb[$];

    calc_window_stats_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    calc_window_stats #(
        .DW(DW),
        .DEPTH(DEPTH),
        .SLIDE_INIT(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int d, input int s, input int q, input int c);
        exp_t e;
        @(negedge clk);
        bus.wable = 1'b1;
        bus.wdata = 3'(d);
        bus.clr   = 1'b0;
        e.s = 5'(s);
        e.q = 8'(q);
        e.c = 3'(c);
        e.f = (c == DEPTH);
        e.m = exp_mode;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.wable = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic do_clr(input logic sl);
        @(negedge clk);
        bus.wable = 1'b0;
        bus.clr   = 1'b1;
        bus.slide = sl;
        @(posedge clk);
        #1;
        bus.clr  = 1'b0;
        exp_mode = sl;
        chk("clr_mode", 32'(bus.mode), 32'(sl));
        chk("clr_wsum", 32'(bus.wsum), 0);
    endtask

    task automatic gap(input int d, input int hold);
        @(negedge clk);
        bus.wable = 1'b0;
        bus.wdata = 3'(d);
        @(posedge clk);
        #1;
        chk("gap_wvalid", 32'(bus.wvalid), 0);
        chk("gap_wsum", 32'(bus.wsum), 32'(hold));
    endtask

    // Monitor: every wvalid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (bus.wvalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_wvalid: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wsum", 32'(bus.wsum), 32'(e.s));
                chk("w2sum", 32'(bus.w2sum), 32'(e.q));
                chk("wcount", 32'(bus.wcount), 32'(e.c));
                chk("wfull", 32'(bus.wfull), 32'(e.f));
                chk("mode", 32'(bus.mode), 32'(e.m));
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        exp_mode  = 1'b1;
        reset     = 1'b1;
        bus.wable = 1'b0;
        bus.wdata = '0;
        bus.clr   = 1'b0;
        bus.slide = 1'b1;
        #3;
        chk("rst_wsum", 32'(bus.wsum), 0);
        chk("rst_w2sum", 32'(bus.w2sum), 0);
        chk("rst_wcount", 32'(bus.wcount), 0);
        chk("rst_wfull", 32'(bus.wfull), 0);
        chk("rst_wvalid", 32'(bus.wvalid), 0);
        chk("rst_mode", 32'(bus.mode), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Sliding fill and eviction
        send(1, 1, 1, 1);
        send(2, 3, 5, 2);
        send(3, 6, 14, 3);
        send(4, 10, 30, 4);
        send(5, 14, 54, 4);
        send(7, 19, 99, 4);
        idle();

        // Cumulative wrap
        do_clr(1'b0);
        send(7, 7, 49, 1);
        send(7, 14, 98, 2);
        send(7, 21, 147, 3);
        send(7, 28, 196, 4);
        send(7, 3, 245, 4);
        idle();

        // Asynchronous reset mid-cycle, then a sample while reset is high
        @(posedge clk);
        #2;
        chk("pre_rst_wsum", 32'(bus.wsum), 3);
        reset = 1'b1;
        #1;
        chk("arst_wsum", 32'(bus.wsum), 0);
        chk("arst_w2sum", 32'(bus.w2sum), 0);
        chk("arst_wcount", 32'(bus.wcount), 0);
        chk("arst_wfull", 32'(bus.wfull), 0);
        chk("arst_mode", 32'(bus.mode), 1);
        exp_mode = 1'b1;
        @(negedge clk);
        bus.wable = 1'b1;
        bus.wdata = 3'd6;
        @(posedge clk);
        #1;
        chk("rsth_wvalid", 32'(bus.wvalid), 0);
        chk("rsth_wcount", 32'(bus.wcount), 0);
        @(negedge clk);
        bus.wable = 1'b0;
        reset     = 1'b0;

        // Clear collides with a sample
        send(6, 6, 36, 1);
        idle();
        @(negedge clk);
        bus.wable = 1'b1;
        bus.wdata = 3'd5;
        bus.clr   = 1'b1;
        bus.slide = 1'b1;
        @(posedge clk);
        #1;
        chk("coll_wsum", 32'(bus.wsum), 0);
        chk("coll_w2sum", 32'(bus.w2sum), 0);
        chk("coll_wcount", 32'(bus.wcount), 0);
        chk("coll_wvalid", 32'(bus.wvalid), 0);
        bus.clr = 1'b0;
        send(5, 5, 25, 1);
        idle();

        // Full-scale sliding then drain with zeros
        do_clr(1'b1);
        for (int i = 1; i <= 10; i++) begin
            int n;
            n = (i < 4) ? i : 4;
            send(7, 7 * n, 49 * n, n);
        end
        send(0, 21, 147, 4);
        send(0, 14, 98, 4);
        send(0, 7, 49, 4);
        send(0, 0, 0, 4);
        idle();

        // Gapped strobe
        do_clr(1'b1);
        send(1, 1, 1, 1);
        gap(2, 1);
        send(3, 4, 10, 2);
        gap(4, 4);
        send(5, 9, 35, 3);
        gap(6, 9);
        send(7, 16, 84, 4);
        gap(0, 16);

        idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
